// File: rtl/fanout_fork_pkg.sv
// fanout_fork_pkg: shared constants and types for the fanout_fork eager fork stage.
package fanout_fork_pkg;

  localparam int FIFO_DEPTH      = 2;
  localparam int OCC_W           = 2;
  localparam int NUM_OUT_DEFAULT = 6;

  typedef logic [NUM_OUT_DEFAULT-1:0] fanout_mask_t;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fanout_fork_fifo2.sv
// fanout_fork_fifo2: two-entry word store with head/tail pointers and a count.
// Data registers are deliberately left unreset; only the bookkeeping is cleared.
module fanout_fork_fifo2 #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        count
);
  import fanout_fork_pkg::*;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic              head_q;
  logic              tail_q;
  logic [OCC_W-1:0]  count_q;

  // Pointer and count bookkeeping; flush wins over any push or pop this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= OCC_W'(OCC_EMPTY);
    end else if (flush) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= OCC_W'(OCC_EMPTY);
    end else begin
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
      if (push && !pop)      count_q <= count_q + OCC_W'(1);
      else if (pop && !push) count_q <= count_q - OCC_W'(1);
    end
  end

  // Word storage is written at the tail; a flushed push is discarded.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail_q] <= wr_data;
  end

  assign rd_data = mem[head_q];
  assign count   = count_q;

endmodule

// File: rtl/fanout_fork.sv
// fanout_fork: eager fork broadcasting one valid/ready stream to NUM_OUT consumers.
// Each enabled consumer sees each word exactly once; a word retires when all
// enabled consumers have taken it. Optional macro FANOUT_FORK_BYPASS_EN gives a
// zero-latency path when the buffer is empty.
module fanout_fork #(
  parameter int NUM_OUT = 6,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [NUM_OUT-1:0] cfg_en,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [1:0]         occupancy
);
  import fanout_fork_pkg::*;

  logic [DATA_W-1:0]  head_data;
  logic [OCC_W-1:0]   count;
  logic               head_valid;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic [NUM_OUT-1:0] acc;
  logic [NUM_OUT-1:0] served;
  logic [NUM_OUT-1:0] done_q;
  logic [NUM_OUT-1:0] done_d;
`ifdef FANOUT_FORK_BYPASS_EN
  logic               bypass;
`endif

  fanout_fork_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (wr_en),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head_data),
    .count   (count)
  );

  // Presentation, per-consumer accepts, retire decision and next served mask.
  always_comb begin
    head_valid = (count != OCC_W'(OCC_EMPTY));
    in_ready   = (count != OCC_W'(OCC_FULL));
    push       = in_valid & in_ready;
    out_valid  = {NUM_OUT{head_valid}} & cfg_en & ~done_q;
    out_data   = head_valid ? head_data : '0;
`ifdef FANOUT_FORK_BYPASS_EN
    bypass = ~head_valid;
    if (bypass) begin
      out_valid = {NUM_OUT{in_valid}} & cfg_en;
      out_data  = in_data;
    end
`endif
    acc    = out_valid & out_ready;
    served = ~cfg_en | done_q | acc;
    pop    = head_valid & (&served);
    wr_en  = push;
    if (pop) done_d = '0;
    else     done_d = done_q | acc;
`ifdef FANOUT_FORK_BYPASS_EN
    if (bypass) begin
      wr_en  = push & ~(&(~cfg_en | acc));
      done_d = wr_en ? acc : '0;
    end
`endif
  end

  // Served mask for the head word; cleared on retire, flush or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     done_q <= '0;
    else if (flush) done_q <= '0;
    else            done_q <= done_d;
  end

  assign occupancy = count;

endmodule

// File: doc/fanout_fork.md
# fanout_fork

Eager fork stage for the CGRA routing fabric. Accepts one valid/ready stream and broadcasts each word to up to NUM_OUT consumers selected by a static enable mask. It tracks per-consumer acceptance so that each consumer sees each word exactly once, and retires a word only when every enabled consumer has taken it. It sits between a tile output port and the fanout ready-combine logic, and absorbs consumer skew with a 2-entry buffer.

## Interface
- NUM_OUT, 6, number of fanout destinations
- DATA_W, 16, payload width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of buffer and acceptance state
- cfg_en  in  NUM_OUT  destination enable mask; quasi-static, changes only while empty
- in_data  in  DATA_W  input payload
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- out_data  out  DATA_W  broadcast payload, shared by all destinations
- out_valid  out  NUM_OUT  per-destination valid
- out_ready  in  NUM_OUT  per-destination ready
- occupancy  out  2  buffered words, 0..2

## Operation
- Storage is a 2-entry FIFO with a head pointer, a tail pointer and a count, plus a head served mask done_q[NUM_OUT].
- Push: in_valid & in_ready.
- in_ready = (count != 2). It depends only on registered state; there is no combinational path from out_ready.
- out_valid[i] = head_valid & cfg_en[i] & ~done_q[i].
- out_data = head entry data.
- Accept per destination: acc[i] = out_valid[i] & out_ready[i].
- Pop: head_valid & AND over i of (~cfg_en[i] | done_q[i] | acc[i]).
- On pop, done_q is cleared to 0. Otherwise done_q |= acc.
- Count update: push & ~pop gives +1; pop & ~push gives −1; push & pop leaves it unchanged. Push & pop together is possible only at count 1.
- At count 2, push cannot occur. A pop at count 2 raises in_ready on the next cycle, not the same cycle.
- cfg_en all zero: the head pops in its first cycle at head, and out_valid stays all 0.
- Each enabled destination receives each word exactly once, in order, including when its out_ready toggles.
- flush: count, pointers and done_q go to 0 on the next edge. flush has priority over a push and a pop in the same cycle.
- Reset: asynchronous assertion clears count, pointers and done_q. The FIFO data registers are not reset.

## Timing
- Reset values: in_ready=1, out_valid=0, occupancy=0, out_data=0.
- Latency without bypass: a word pushed at edge N is presented at edge N+1.
- Throughput: 1 word/cycle when all enabled consumers are ready.
- A consumer stalled on word k stalls only itself. Other consumers complete word k, then wait.
- Retiring happens on the edge where the last missing accept occurs. The next word is presented in the following cycle.
- rst_n deasserted mid-stream: all words in flight are dropped, and no out_valid is visible in the first cycle after release.

## Configuration
- FANOUT_FORK_BYPASS_EN defined:
  - When count==0, out_data=in_data and out_valid[i]=in_valid & cfg_en[i].
  - If all enabled destinations accept in that cycle, nothing is written.
  - Otherwise the word is written as the head, with done_q preset to the accepting set.
  - Result is 0-cycle latency.
- FANOUT_FORK_BYPASS_EN undefined:
  - All words pass through storage, giving a 1-cycle minimum latency.
  - There is no combinational in→out path.

## Structure
- Package fanout_fork_pkg holds:
  - localparam FIFO_DEPTH=2 and the occupancy width;
  - typedef fanout_mask_t (logic [NUM_OUT-1:0] default 6);
  - typedef occ_e enum {OCC_EMPTY, OCC_ONE, OCC_FULL}.
- Sub-module fanout_fork_fifo2:
  - 2-entry data storage and pointers with push/pop/flush;
  - fanout_fork holds the done_q mask and the retire logic.

## Test plan
- cfg_en=6'b000111, all out_ready=1, stream 0x0001..0x0010 back-to-back → each of dests 0-2 sees 16 words in order, one per cycle; dests 3-5 out_valid never 1.
- cfg_en=6'b000011, out_ready[1]=0 for 5 cycles, push 0xA5A5, 0x5A5A, 0x1234 → dest0 takes 0xA5A5 once; in_ready drops after 2 words buffered; on release dest1 takes 0xA5A5, then both get 0x5A5A, 0x1234; no duplicates.
- cfg_en=0, push 4 words → each retires in one cycle, out_valid=0 throughout, occupancy never exceeds 1.
- occupancy=2, flush=1 with in_valid=1 → next cycle occupancy=0, out_valid=0, pushed word discarded.
- rst_n pulled low mid-stream with 2 buffered words → out_valid=0 and in_ready=1 immediately; after release, no stale word appears.
- With FANOUT_FORK_BYPASS_EN, empty, all ready, in_data=0xBEEF → out_data=0xBEEF with out_valid same cycle, occupancy stays 0; with one dest not ready → word stored, that dest alone gets it next cycle.
